dbg_responder: RTL

- Debug-side responder for the pipelined processor: the hardware end of the register and cycle observation that benches currently perform with hierarchical peeks.
- Accepts commands from a debug host over a valid/ready request channel.
- Reads the register file through a spare read port, maintains cycle and retire counters, and halts, resumes or single-steps the core via a stall line.
- Sits beside the register file and hazard/stall unit inside Top.

---
 rtl/dbg_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dbg_responder.sv
// dbg_responder: debug host command engine for register reads, cycle/retire counters and halt/step control
module dbg_responder #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int RF_LAT        = 1,
    parameter int HALT_ON_RESET = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [2:0]        dbg_cmd,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [7:0]        dbg_arg,
    output logic              dbg_rsp_valid,
    input  logic              dbg_rsp_ready,
    output logic [DATA_W-1:0] dbg_rsp_data,
    output logic              dbg_rsp_err,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    input  logic              cpu_retire,
    output logic              cpu_stall,
    output logic              halted
);
    typedef enum logic [2:0] {IDLE, RF_RD, RF_WAIT, STEP, RESP} state_t;

    localparam logic [2:0] OP_READ_REG = 3'd1;
    localparam logic [2:0] OP_READ_CYC = 3'd2;
    localparam logic [2:0] OP_HALT     = 3'd3;
    localparam logic [2:0] OP_RESUME   = 3'd4;
    localparam logic [2:0] OP_STEP     = 3'd5;
    localparam logic [2:0] OP_READ_RET = 3'd6;
    localparam logic [2:0] OP_BAD      = 3'd7;
    localparam logic [1:0] LAT_SAMPLE  = 2'(RF_LAT - 1);
    localparam logic [1:0] LAT_DONE    = 2'(RF_LAT);

    state_t            state, state_nxt;
    logic              pend;
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        arg, step_cnt;
    logic [1:0]        wait_cnt;
    logic [DATA_W-1:0] cyc, ret, cyc_nxt, ret_nxt, data, data_nxt;
    logic              err, err_nxt, stall, stall_nxt, hlt, hlt_nxt;

    assign cyc_nxt       = stall ? cyc : cyc + 1'b1;
    assign ret_nxt       = cpu_retire ? ret + 1'b1 : ret;
    assign dbg_req_ready = (state == IDLE) && !pend;
    assign dbg_rsp_valid = state == RESP;
    assign dbg_rsp_data  = data;
    assign dbg_rsp_err   = err;
    assign rf_rd_en      = state == RF_RD;
    assign rf_rd_addr    = addr;
    assign cpu_stall     = stall;
    assign halted        = hlt;

    // Next state, response payload and run control; counter reads capture the value the counter takes at the RESP-entry edge
    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        err_nxt   = err;
        stall_nxt = stall;
        hlt_nxt   = hlt;
        case (state)
            IDLE: begin
                if (pend) begin
                    state_nxt = RESP;
                    data_nxt  = '0;
                    err_nxt   = 1'b0;
                    case (cmd)
                        OP_READ_CYC: data_nxt = cyc_nxt;
                        OP_READ_RET: data_nxt = ret_nxt;
                        OP_BAD:      err_nxt  = 1'b1;
                        OP_HALT: begin
                            data_nxt  = cyc_nxt;
                            stall_nxt = 1'b1;
                            hlt_nxt   = 1'b1;
                        end
                        OP_RESUME: begin
                            data_nxt  = ret_nxt;
                            stall_nxt = 1'b0;
                            hlt_nxt   = 1'b0;
                        end
                        OP_STEP: begin
                            err_nxt   = !(hlt && arg != 8'd0);
                            state_nxt = err_nxt ? RESP : STEP;
                            stall_nxt = err_nxt ? stall : 1'b0;
                        end
                        default: ;
                    endcase
                end else if (dbg_req_valid && dbg_cmd == OP_READ_REG) begin
                    state_nxt = RF_RD;
                end
            end
            RF_RD: begin
                state_nxt = RF_WAIT;
                err_nxt   = 1'b0;
            end
            RF_WAIT: begin
                data_nxt  = (wait_cnt == LAT_SAMPLE) ? rf_rd_data : data;
                state_nxt = (wait_cnt == LAT_DONE) ? RESP : RF_WAIT;
            end
            STEP: begin
                if (cpu_retire && 8'(step_cnt + 8'd1) == arg) begin
                    state_nxt = RESP;
                    stall_nxt = 1'b1;
                    data_nxt  = ret_nxt;
                    err_nxt   = 1'b0;
                end
            end
            RESP: state_nxt = dbg_rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // State, command latch, counters and sequencing registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= 1'b0;
            cmd      <= '0;
            addr     <= '0;
            arg      <= '0;
            data     <= '0;
            err      <= 1'b0;
            stall    <= HALT_ON_RESET != 0;
            hlt      <= HALT_ON_RESET != 0;
            cyc      <= '0;
            ret      <= '0;
            step_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            data     <= data_nxt;
            err      <= err_nxt;
            stall    <= stall_nxt;
            hlt      <= hlt_nxt;
            cyc      <= cyc_nxt;
            ret      <= ret_nxt;
            pend     <= dbg_req_valid && dbg_req_ready && dbg_cmd != OP_READ_REG;
            wait_cnt <= (state == RF_WAIT) ? wait_cnt + 2'd1 : 2'd0;
            step_cnt <= (state == STEP) ? step_cnt + 8'(cpu_retire) : 8'd0;
            if (dbg_req_valid && dbg_req_ready) begin
                cmd  <= dbg_cmd;
                addr <= dbg_addr;
                arg  <= dbg_arg;
            end
        end
    end
endmodule
